cgra_mem_port_arbiter: RTL and testbench

- Reduces the CGRA's 9 OBI master ports to 4 external-crossbar master ports, so the interleaved memory sees only 4 masters.
- Each CGRA requester is statically assigned to one output port.
- Each port runs a locked round-robin arbiter and keeps an in-order response-routing ID FIFO.
- Sits between the CGRA master ports and the ext xbar master inputs inside the sonhamos SoC top.

---
 rtl/cgra_mem_port_arbiter_pkg.sv | 20 ++
 rtl/cgra_mem_port_arbiter_rr_arb.sv | 145 ++++++++++++++
 rtl/cgra_mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_cgra_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_mem_port_arbiter_pkg.sv
// rtl/cgra_mem_port_arbiter_pkg.sv - shared sizes and requester-to-port mapping for the CGRA memory port arbiter
package cgra_mem_port_arbiter_pkg;

  localparam int CGRA_XBAR_NMASTER         = 9;
  localparam int CGRA_XBAR_NPORT           = 4;
  localparam int CGRA_PORT_MAX_OUTSTANDING = 2;
  localparam int DW                        = 32;
  localparam int BEW                       = 4;

  // Static assignment of a requester to its output port.
  function automatic int req2port(input int r, input int nport = CGRA_XBAR_NPORT);
    return r % nport;
  endfunction

  // Number of requesters sharing output port p.
  function automatic int port_members(input int nreq, input int nport, input int p);
    return (nreq - p + nport - 1) / nport;
  endfunction

endpackage

// File: rtl/cgra_mem_port_arbiter_rr_arb.sv
// rtl/cgra_mem_port_arbiter_rr_arb.sv - per-port locked round-robin arbiter with in-order response ID FIFO
module cgra_port_id_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

  // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

module cgra_port_rr_arb
  import cgra_mem_port_arbiter_pkg::*;
#(
  parameter int NMEM     = 3,
  parameter int NPORT    = 4,
  parameter int PORT_IDX = 0,
  parameter int IDW      = 4,
  parameter int DEPTH    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NMEM-1:0]           req,
  input  logic [NMEM-1:0][DW-1:0]   addr,
  input  logic [NMEM-1:0]           we,
  input  logic [NMEM-1:0][BEW-1:0]  be,
  input  logic [NMEM-1:0][DW-1:0]   wdata,
  output logic [NMEM-1:0]           gnt,
  output logic                      port_req,
  input  logic                      port_gnt,
  output logic [DW-1:0]             port_addr,
  output logic                      port_we,
  output logic [BEW-1:0]            port_be,
  output logic [DW-1:0]             port_wdata,
  input  logic                      port_rvalid,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic                      spurious
);

  localparam int LW = (NMEM > 1) ? $clog2(NMEM) : 1;

  logic [LW-1:0]  last_q, lock_sel_q, rr_sel, sel;
  logic           lock_q, rr_found, hs, fifo_full, fifo_empty;
  logic [IDW-1:0] push_id;

  // Round-robin pick starting at the member after the last granted one.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NMEM; k++) begin
      if (!rr_found && req[(int'(last_q) + k) % NMEM]) begin
        rr_found = 1'b1;
        rr_sel   = LW'((int'(last_q) + k) % NMEM);
      end
    end
  end

  // A pending unacknowledged request keeps its selection until the handshake.
  assign sel        = lock_q ? lock_sel_q : rr_sel;
  assign port_req   = rst_ni & ~fifo_full & (lock_q ? req[sel] : rr_found);
  assign hs         = port_req & port_gnt;
  assign port_addr  = addr[sel];
  assign port_we    = we[sel];
  assign port_be    = be[sel];
  assign port_wdata = wdata[sel];
  assign push_id    = IDW'(PORT_IDX + NPORT * int'(sel));

  // Only the selected requester may see the grant.
  always_comb begin
    gnt      = '0;
    gnt[sel] = hs;
  end

  // Lock and last-granted bookkeeping; last-granted starts at the highest member.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= LW'(NMEM - 1);
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      lock_q <= port_req & ~port_gnt;
      if (port_req & ~port_gnt) lock_sel_q <= sel;
      if (hs) last_q <= sel;
    end
  end

  assign rsp_valid = port_rvalid & ~fifo_empty;
  assign spurious  = port_rvalid & fifo_empty;

  cgra_port_id_fifo #(
    .W     (IDW),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (hs),
    .push_data (push_id),
    .pop       (rsp_valid),
    .head      (rsp_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: rtl/cgra_mem_port_arbiter.sv
// rtl/cgra_mem_port_arbiter.sv - folds NREQ CGRA OBI masters onto NPORT xbar masters; SONHAMOS_ARB_PERF_EN adds perf_stall_o
module cgra_mem_port_arbiter
  import cgra_mem_port_arbiter_pkg::*;
#(
  parameter int NREQ            = CGRA_XBAR_NMASTER,
  parameter int NPORT           = CGRA_XBAR_NPORT,
  parameter int MAX_OUTSTANDING = CGRA_PORT_MAX_OUTSTANDING,
  parameter int IDW             = $clog2(NREQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_req_i,
  output logic [NREQ-1:0]           req_gnt_o,
  input  logic [NREQ-1:0][DW-1:0]   req_addr_i,
  input  logic [NREQ-1:0]           req_we_i,
  input  logic [NREQ-1:0][BEW-1:0]  req_be_i,
  input  logic [NREQ-1:0][DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]           req_rvalid_o,
  output logic [NREQ-1:0][DW-1:0]   req_rdata_o,
  output logic [NPORT-1:0]          port_req_o,
  input  logic [NPORT-1:0]          port_gnt_i,
  output logic [NPORT-1:0][DW-1:0]  port_addr_o,
  output logic [NPORT-1:0]          port_we_o,
  output logic [NPORT-1:0][BEW-1:0] port_be_o,
  output logic [NPORT-1:0][DW-1:0]  port_wdata_o,
  input  logic [NPORT-1:0]          port_rvalid_i,
  input  logic [NPORT-1:0][DW-1:0]  port_rdata_i,
  output logic                      err_o
`ifdef SONHAMOS_ARB_PERF_EN
  ,
  output logic [NPORT-1:0][31:0]    perf_stall_o
`endif
);

  logic [NPORT-1:0]          rsp_valid, spurious;
  logic [NPORT-1:0][IDW-1:0] rsp_id;
  logic                      err_q;
`ifdef SONHAMOS_ARB_PERF_EN
  logic [NPORT-1:0]          stall;
  logic [NPORT-1:0][31:0]    stall_cnt_q;
`endif

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    localparam int NMEM = port_members(NREQ, NPORT, p);

    logic [NMEM-1:0]          l_req, l_we, l_gnt;
    logic [NMEM-1:0][DW-1:0]  l_addr, l_wdata;
    logic [NMEM-1:0][BEW-1:0] l_be;

    for (genvar m = 0; m < NMEM; m++) begin : g_mem
      assign l_req[m]                = req_req_i[p + m * NPORT];
      assign l_we[m]                 = req_we_i[p + m * NPORT];
      assign l_addr[m]               = req_addr_i[p + m * NPORT];
      assign l_wdata[m]              = req_wdata_i[p + m * NPORT];
      assign l_be[m]                 = req_be_i[p + m * NPORT];
      assign req_gnt_o[p + m * NPORT] = l_gnt[m];
    end

`ifdef SONHAMOS_ARB_PERF_EN
    assign stall[p] = (|l_req) & ~(port_req_o[p] & port_gnt_i[p]);
`endif

    cgra_port_rr_arb #(
      .NMEM     (NMEM),
      .NPORT    (NPORT),
      .PORT_IDX (p),
      .IDW      (IDW),
      .DEPTH    (MAX_OUTSTANDING)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req         (l_req),
      .addr        (l_addr),
      .we          (l_we),
      .be          (l_be),
      .wdata       (l_wdata),
      .gnt         (l_gnt),
      .port_req    (port_req_o[p]),
      .port_gnt    (port_gnt_i[p]),
      .port_addr   (port_addr_o[p]),
      .port_we     (port_we_o[p]),
      .port_be     (port_be_o[p]),
      .port_wdata  (port_wdata_o[p]),
      .port_rvalid (port_rvalid_i[p]),
      .rsp_valid   (rsp_valid[p]),
      .rsp_id      (rsp_id[p]),
      .spurious    (spurious[p])
    );
  end

  // Route each response to the requester at the head of its port's ID FIFO.
  for (genvar r = 0; r < NREQ; r++) begin : g_rsp
    localparam int P = req2port(r, NPORT);
    assign req_rvalid_o[r] = rsp_valid[P] && (rsp_id[P] == IDW'(r));
    assign req_rdata_o[r]  = req_rvalid_o[r] ? port_rdata_i[P] : '0;
  end

  // Sticky error on any response with no outstanding transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (|spurious) err_q <= 1'b1;
  end

  assign err_o = err_q;

`ifdef SONHAMOS_ARB_PERF_EN
  // Saturating per-port count of cycles where a waiting requester got no grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (stall[p] && (stall_cnt_q[p] != 32'hFFFF_FFFF)) stall_cnt_q[p] <= stall_cnt_q[p] + 32'd1;
      end
    end
  end

  assign perf_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_mem_port_arbiter.sv
// tb/tb_cgra_mem_port_arbiter.sv - scoreboard bench for cgra_mem_port_arbiter
module tb_cgra_mem_port_arbiter;

  localparam int NREQ  = 9;
  localparam int NPORT = 4;

  logic                     clk = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NREQ-1:0]          req_req_i, req_gnt_o, req_we_i, req_rvalid_o;
  logic [NREQ-1:0][31:0]    req_addr_i, req_wdata_i, req_rdata_o;
  logic [NREQ-1:0][3:0]     req_be_i;
  logic [NPORT-1:0]         port_req_o, port_gnt_i, port_we_o, port_rvalid_i;
  logic [NPORT-1:0][31:0]   port_addr_o, port_wdata_o, port_rdata_i;
  logic [NPORT-1:0][3:0]    port_be_o;
  logic                     err_o;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  cgra_mem_port_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_req_i     (req_req_i),
    .req_gnt_o     (req_gnt_o),
    .req_addr_i    (req_addr_i),
    .req_we_i      (req_we_i),
    .req_be_i      (req_be_i),
    .req_wdata_i   (req_wdata_i),
    .req_rvalid_o  (req_rvalid_o),
    .req_rdata_o   (req_rdata_o),
    .port_req_o    (port_req_o),
    .port_gnt_i    (port_gnt_i),
    .port_addr_o   (port_addr_o),
    .port_we_o     (port_we_o),
    .port_be_o     (port_be_o),
    .port_wdata_o  (port_wdata_o),
    .port_rvalid_i (port_rvalid_i),
    .port_rdata_i  (port_rdata_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req_req_i     = '0;
    req_we_i      = '0;
    req_be_i      = '1;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    port_gnt_i    = '0;
    port_rvalid_i = '0;
    port_rdata_i  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic push_rsp(input int port, input int idx, input logic [31:0] data);
    port_rvalid_i[port] = 1'b1;
    port_rdata_i[port]  = data;
    sb_q.push_back('{idx, data});
  endtask

  task automatic check_rsp(input string tag);
    rsp_t        e;
    logic [31:0] others;
    check({tag, "_pending"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      others = '0;
      for (int i = 0; i < NREQ; i++) if (i != e.idx) others |= req_rdata_o[i];
      check({tag, "_vec"}, 32'(req_rvalid_o), 32'(1) << e.idx);
      check({tag, "_data"}, req_rdata_o[e.idx], e.data);
      check({tag, "_others"}, others, 32'd0);
    end
  endtask

  initial begin
    int order[3];
    order[0] = 0; order[1] = 4; order[2] = 8;

    // reset state, with requests and grants driven during reset
    clear_inputs();
    req_req_i  = '1;
    port_gnt_i = '1;
    repeat (2) @(posedge clk);
    sample();
    check("rst_port_req", 32'(port_req_o), 32'd0);
    check("rst_gnt", 32'(req_gnt_o), 32'd0);
    check("rst_rvalid", 32'(req_rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    #1 do_reset();

    // single read from r0
    step();
    req_req_i[0] = 1'b1; req_addr_i[0] = 32'h1000; port_gnt_i[0] = 1'b1;
    sample();
    check("t1_gnt", 32'(req_gnt_o), 32'h001);
    check("t1_port_req", 32'(port_req_o), 32'h1);
    check("t1_addr", port_addr_o[0], 32'h1000);
    step();
    req_req_i[0] = 1'b0; port_gnt_i[0] = 1'b0;
    push_rsp(0, 0, 32'hDEADBEEF);
    sample();
    check_rsp("t1_rsp");
    check("t1_err", 32'(err_o), 32'd0);
    do_reset();

    // continuous round robin on port0 with one-cycle response latency
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        for (int j = 0; j < 3; j++) begin
          req_req_i[order[j]]  = 1'b1;
          req_addr_i[order[j]] = 32'h100 * (j + 1);
        end
        port_gnt_i[0] = 1'b1;
      end
      if (k == 6) begin
        req_req_i = '0; port_gnt_i = '0;
      end
      port_rvalid_i[0] = 1'b0;
      if (k > 0) push_rsp(0, order[(k - 1) % 3], 32'hA000_0000 + 32'(k - 1));
      sample();
      if (k < 6) begin
        check($sformatf("t2_gnt%0d", k), 32'(req_gnt_o), 32'(1) << order[k % 3]);
        check($sformatf("t2_addr%0d", k), port_addr_o[0], 32'h100 * 32'((k % 3) + 1));
      end
      if (k > 0) check_rsp($sformatf("t2_rsp%0d", k));
    end
    do_reset();

    // lock holds r4 while gnt is low, r0 arrives later
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin req_req_i[4] = 1'b1; req_addr_i[4] = 32'h2000; end
      if (k == 1) begin req_req_i[0] = 1'b1; req_addr_i[0] = 32'h3000; end
      if (k == 3) port_gnt_i[0] = 1'b1;
      if (k == 4) req_req_i[4] = 1'b0;
      sample();
      check($sformatf("t3_addr%0d", k), port_addr_o[0], (k < 4) ? 32'h2000 : 32'h3000);
      check($sformatf("t3_gnt%0d", k), 32'(req_gnt_o), (k < 3) ? 32'd0 : ((k == 3) ? 32'h010 : 32'h001));
      if (k < 3) check($sformatf("t3_port_req%0d", k), 32'(port_req_o[0]), 32'd1);
    end
    step();
    req_req_i = '0; port_gnt_i = '0;
    push_rsp(0, 4, 32'h4444_0004);
    sample();
    check_rsp("t3_rsp4");
    step();
    push_rsp(0, 0, 32'h5555_0000);
    sample();
    check_rsp("t3_rsp0");
    do_reset();

    // outstanding limit on port1
    step();
    req_req_i[1] = 1'b1; port_gnt_i[1] = 1'b1;
    sample();
    check("t4_gnt0", 32'(req_gnt_o), 32'h002);
    step();
    sample();
    check("t4_gnt1", 32'(req_gnt_o), 32'h002);
    step();
    sample();
    check("t4_full_req", 32'(port_req_o[1]), 32'd0);
    check("t4_full_gnt", 32'(req_gnt_o), 32'd0);
    step();
    push_rsp(1, 1, 32'h1111_1111);
    sample();
    check_rsp("t4_rsp0");
    check("t4_pop_req", 32'(port_req_o[1]), 32'd0);
    step();
    port_rvalid_i[1] = 1'b0;
    sample();
    check("t4_reassert", 32'(port_req_o[1]), 32'd1);
    check("t4_gnt2", 32'(req_gnt_o), 32'h002);
    step();
    req_req_i = '0; port_gnt_i = '0;
    push_rsp(1, 1, 32'h2222_2222);
    sample();
    check_rsp("t4_rsp1");
    step();
    push_rsp(1, 1, 32'h3333_3333);
    sample();
    check_rsp("t4_rsp2");
    do_reset();

    // independent ports 1 and 2 in the same cycle
    step();
    req_req_i[1] = 1'b1; req_req_i[2] = 1'b1;
    port_gnt_i[1] = 1'b1; port_gnt_i[2] = 1'b1;
    sample();
    check("t5_gnt", 32'(req_gnt_o), 32'h006);
    check("t5_port_req", 32'(port_req_o), 32'h6);
    step();
    req_req_i = '0; port_gnt_i = '0;
    push_rsp(2, 2, 32'h0000_0002);
    sample();
    check_rsp("t5_rsp2");
    step();
    port_rvalid_i = '0;
    push_rsp(1, 1, 32'h0000_0001);
    sample();
    check_rsp("t5_rsp1");
    do_reset();

    // spurious response on an empty port and sticky error
    step();
    port_rvalid_i[3] = 1'b1; port_rdata_i[3] = 32'h0000_0BAD;
    sample();
    check("t6_no_rvalid", 32'(req_rvalid_o), 32'd0);
    check("t6_rdata3", req_rdata_o[3], 32'd0);
    step();
    port_rvalid_i = '0;
    sample();
    check("t6_err_set", 32'(err_o), 32'd1);
    repeat (3) step();
    sample();
    check("t6_err_sticky", 32'(err_o), 32'd1);

    // asynchronous reset in the middle of a transaction
    step();
    req_req_i[0] = 1'b1; req_req_i[3] = 1'b1; port_gnt_i[0] = 1'b1;
    sample();
    check("t6_pre_req", 32'(port_req_o), 32'h9);
    step();
    port_gnt_i[0] = 1'b0; req_req_i[0] = 1'b0;
    port_rvalid_i[0] = 1'b1; port_rdata_i[0] = 32'h7777_7777;
    #1 rst_ni = 1'b0;
    #1;
    check("t6_rst_port_req", 32'(port_req_o), 32'd0);
    check("t6_rst_gnt", 32'(req_gnt_o), 32'd0);
    check("t6_rst_rvalid", 32'(req_rvalid_o), 32'd0);
    check("t6_rst_rdata0", req_rdata_o[0], 32'd0);
    check("t6_rst_err", 32'(err_o), 32'd0);
    step();
    rst_ni = 1'b1;
    req_req_i = '0;
    sample();
    check("t6_late_rvalid", 32'(req_rvalid_o), 32'd0);
    step();
    port_rvalid_i = '0;
    sample();
    check("t6_late_err", 32'(err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
